micro_alpha_veryl_seq_shifter: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit micro1 shifter.
- Shifts or rotates a WIDTH-bit word by a variable amount, up to STEP bits per clock.
- Uses a valid/ready handshake on both input and output.
- Sits between the register-file read port and the ALU result bus; it handles multi-bit shift instructions that the single-cycle shifter cannot.

---
 rtl/micro_alpha_veryl_seq_shifter.sv | 199 +++++++++++++++++++
 tb/tb_micro_alpha_veryl_seq_shifter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_alpha_veryl_seq_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bits per clock on a WIDTH-bit word.
// Latency: out_valid 1+ceil(amount/STEP) cycles after accept; NOP/SWAP/amount 0 take 1 cycle.
// Backpressure: result held stable in DONE until out_ready; a new request may load on the same edge.
// Optional: define MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN to build the sticky SLA overflow flag.
module micro_alpha_veryl_seq_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amount,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_cout,
    output logic                       out_overflow
);

    localparam int AW  = $clog2(WIDTH);
    localparam int AW1 = AW + 1;
    // One extra bit so that STEP == WIDTH is representable.
    localparam logic [AW:0] STEP_L = AW1'(STEP);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_SLA  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              cin_q, cin_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic              cout_q, cout_d;

    logic [AW:0]       k;
    logic [WIDTH-1:0]  sh_dat;
    logic              sh_cout;
    logic              accept;

`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
    logic              ovf_q, ovf_d;
    logic              sh_ovf;
`endif

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        out_valid = (state_q == S_DONE);
        in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_data  = data_q;
        out_cout  = cout_q;
    end

`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
    assign out_overflow = ovf_q;
`else
    assign out_overflow = 1'b0;
`endif

    // One SHIFT step: k = min(STEP, remaining) single-bit moves chained combinationally,
    // so cout naturally ends up as the last bit pushed out in this step.
    always_comb begin
        k       = ({1'b0, rem_q} > STEP_L) ? STEP_L : {1'b0, rem_q};
        sh_dat  = data_q;
        sh_cout = cout_q;
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
        sh_ovf  = ovf_q;
`endif
        for (int i = 0; i < STEP; i++) begin
            if (AW1'(i) < k) begin
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
                // MSB after a left move is the current bit WIDTH-2.
                if ((op_q == OP_SLA) && (sh_dat[WIDTH-1] != sh_dat[WIDTH-2])) begin
                    sh_ovf = 1'b1;
                end
`endif
                case (op_q)
                    OP_SLL, OP_SLA: begin
                        sh_cout = sh_dat[WIDTH-1];
                        sh_dat  = {sh_dat[WIDTH-2:0], cin_q};
                    end
                    OP_SRL: begin
                        sh_cout = sh_dat[0];
                        sh_dat  = {cin_q, sh_dat[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        sh_cout = sh_dat[0];
                        sh_dat  = {sh_dat[WIDTH-1], sh_dat[WIDTH-1:1]};
                    end
                    OP_ROL: begin
                        sh_cout = sh_dat[WIDTH-1];
                        sh_dat  = {sh_dat[WIDTH-2:0], sh_dat[WIDTH-1]};
                    end
                    OP_ROR: begin
                        sh_cout = sh_dat[0];
                        sh_dat  = {sh_dat[0], sh_dat[WIDTH-1:1]};
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Next-state: advance the current operation, then let an accept override everything
    // so a request can load directly out of DONE without an IDLE bubble.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cin_d   = cin_q;
        rem_d   = rem_q;
        cout_d  = cout_q;
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_SHIFT: begin
                data_d = sh_dat;
                cout_d = sh_cout;
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
                ovf_d  = sh_ovf;
`endif
                rem_d  = rem_q - k[AW-1:0];
                if (rem_q == k[AW-1:0]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            op_d   = in_op;
            data_d = in_data;
            cin_d  = in_cin;
            rem_d  = in_amount;
            cout_d = 1'b0;
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
            ovf_d  = 1'b0;
`endif
            if ((in_op == OP_NOP) || (in_op == OP_SWAP) || (in_amount == '0)) begin
                state_d = S_DONE;
                if (in_op == OP_SWAP) begin
                    data_d = {in_data[WIDTH/2-1:0], in_data[WIDTH-1:WIDTH/2]};
                end
            end else begin
                state_d = S_SHIFT;
            end
        end
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cin_q   <= 1'b0;
            rem_q   <= '0;
            cout_q  <= 1'b0;
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cin_q   <= cin_d;
            rem_q   <= rem_d;
            cout_q  <= cout_d;
`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_micro_alpha_veryl_seq_shifter.sv
// Directed bench for the sequential shifter: STEP=1 main instance plus a STEP=4 instance.
// Latency is counted as 1 at the first sample after the accept edge.
// Outputs are sampled #1 after the rising edge; inputs driven with blocking assignments.
module tb_micro_alpha_veryl_seq_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  in_amount = 4'd0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_cout;
    logic        out_overflow;

    logic        v4 = 1'b0;
    logic        r4;
    logic        o4_valid;
    logic [15:0] o4_data;
    logic        o4_cout;
    logic        o4_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

`ifdef MICRO_ALPHA_VERYL_SEQ_SHIFTER_OVERFLOW_EN
    logic ovf_exp = 1'b1;
`else
    logic ovf_exp = 1'b0;
`endif

    always #5 clk = ~clk;

    micro_alpha_veryl_seq_shifter #(.WIDTH(16), .STEP(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .in_amount(in_amount), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout), .out_overflow(out_overflow)
    );

    micro_alpha_veryl_seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(r4),
        .in_op(in_op), .in_data(in_data), .in_amount(in_amount), .in_cin(in_cin),
        .out_valid(o4_valid), .out_ready(out_ready),
        .out_data(o4_data), .out_cout(o4_cout), .out_overflow(o4_ovf)
    );

    // Issue one request to the STEP=1 instance and wait (bounded) for its result.
    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt,
                        input logic cin, output int l);
        in_valid = 1'b1; in_op = op; in_data = d; in_amount = amt; in_cin = cin;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'hDEAD; in_amount = 4'hF; in_cin = 1'b1;
        l = 1;
        while (!out_valid && l < 64) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL rst_data got %h want 0000", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout got %b want 0", out_cout); end
        n_cmp++; if (out_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", out_overflow); end
        n_cmp++; if (o4_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid4 got %b want 0", o4_valid); end
    endtask

    task automatic test_sll();
        send(3'd1, 16'hA5A5, 4'd4, 1'b0, lat);
        n_cmp++; if (out_data !== 16'h5A50) begin n_bad++; $display("FAIL sll_data got %h want 5a50", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL sll_cout got %b want 0", out_cout); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL sll_lat got %0d want 5", lat); end
    endtask

    task automatic test_srl();
        send(3'd2, 16'hA5A5, 4'd1, 1'b1, lat);
        n_cmp++; if (out_data !== 16'hD2D2) begin n_bad++; $display("FAIL srl_data got %h want d2d2", out_data); end
        n_cmp++; if (out_cout !== 1'b1) begin n_bad++; $display("FAIL srl_cout got %b want 1", out_cout); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL srl_lat got %0d want 2", lat); end
    endtask

    // SRA by 15 on both instances launched on the same edge.
    task automatic test_sra_step();
        int l4;
        logic [15:0] d4;
        logic c4;
        l4 = 0; d4 = 16'h0; c4 = 1'b1;
        n_cmp++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL sra4_ready got %b want 1", r4); end
        in_valid = 1'b1; v4 = 1'b1; in_op = 3'd4; in_data = 16'h8000; in_amount = 4'd15; in_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; v4 = 1'b0; in_data = 16'h1234;
        lat = 1;
        for (int c = 0; c < 64; c++) begin
            if (o4_valid && l4 == 0) begin
                l4 = lat; d4 = o4_data; c4 = o4_cout;
            end
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (out_data !== 16'hFFFF) begin n_bad++; $display("FAIL sra_data got %h want ffff", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL sra_cout got %b want 0", out_cout); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL sra_lat got %0d want 16", lat); end
        n_cmp++; if (d4 !== 16'hFFFF) begin n_bad++; $display("FAIL sra4_data got %h want ffff", d4); end
        n_cmp++; if (c4 !== 1'b0) begin n_bad++; $display("FAIL sra4_cout got %b want 0", c4); end
        n_cmp++; if (l4 !== 5) begin n_bad++; $display("FAIL sra4_lat got %0d want 5", l4); end
    endtask

    task automatic test_rotate();
        send(3'd5, 16'h0123, 4'd4, 1'b1, lat);
        n_cmp++; if (out_data !== 16'h1230) begin n_bad++; $display("FAIL rol_data got %h want 1230", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL rol_cout got %b want 0", out_cout); end
        send(3'd6, 16'h0001, 4'd1, 1'b0, lat);
        n_cmp++; if (out_data !== 16'h8000) begin n_bad++; $display("FAIL ror_data got %h want 8000", out_data); end
        n_cmp++; if (out_cout !== 1'b1) begin n_bad++; $display("FAIL ror_cout got %b want 1", out_cout); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ror_lat got %0d want 2", lat); end
    endtask

    task automatic test_swap_nop();
        send(3'd7, 16'h0123, 4'd7, 1'b1, lat);
        n_cmp++; if (out_data !== 16'h2301) begin n_bad++; $display("FAIL swap_data got %h want 2301", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL swap_cout got %b want 0", out_cout); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL swap_lat got %0d want 1", lat); end
        send(3'd0, 16'h0123, 4'd3, 1'b1, lat);
        n_cmp++; if (out_data !== 16'h0123) begin n_bad++; $display("FAIL nop_data got %h want 0123", out_data); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL nop_lat got %0d want 1", lat); end
    endtask

    // Stall the result for 3 cycles, then consume it while loading the next request.
    task automatic test_back_to_back();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd1, 16'h0003, 4'd2, 1'b0, lat);
        n_cmp++; if (out_data !== 16'h000C) begin n_bad++; $display("FAIL bp_data got %h want 000c", out_data); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_lat got %0d want 3", lat); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", c, out_valid); end
            n_cmp++; if (out_data !== 16'h000C) begin n_bad++; $display("FAIL bp_hold_data cyc %0d got %h want 000c", c, out_data); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready cyc %0d got %b want 0", c, in_ready); end
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd2; in_data = 16'h00F0; in_amount = 4'd4; in_cin = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'hFFFF;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got %b want 0", in_ready); end
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (out_data !== 16'h000F) begin n_bad++; $display("FAIL b2b_data got %h want 000f", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL b2b_cout got %b want 0", out_cout); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL b2b_lat got %0d want 5", lat); end
    endtask

    task automatic test_overflow();
        send(3'd3, 16'h4000, 4'd1, 1'b0, lat);
        n_cmp++; if (out_data !== 16'h8000) begin n_bad++; $display("FAIL sla1_data got %h want 8000", out_data); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL sla1_cout got %b want 0", out_cout); end
        n_cmp++; if (out_overflow !== ovf_exp) begin n_bad++; $display("FAIL sla1_ovf got %b want %b", out_overflow, ovf_exp); end
        send(3'd3, 16'h0001, 4'd3, 1'b0, lat);
        n_cmp++; if (out_data !== 16'h0008) begin n_bad++; $display("FAIL sla2_data got %h want 0008", out_data); end
        n_cmp++; if (out_overflow !== 1'b0) begin n_bad++; $display("FAIL sla2_ovf got %b want 0", out_overflow); end
    endtask

    // Reset in the middle of SHIFT must drop the operation with no result.
    task automatic test_reset_mid();
        int seen;
        in_valid = 1'b1; in_op = 3'd1; in_data = 16'h00FF; in_amount = 4'd8; in_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL midrst_data got %h want 0000", out_data); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sll();
        test_srl();
        test_sra_step();
        test_rotate();
        test_swap_nop();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
